bram_sync_fifo: RTL
===================

# bram_sync_fifo

Single-clock FIFO built on an inferred block RAM, parametrised in data width and depth, with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush. It is the buffering stage between particle producers (propagate/weight units) and consumers (resampler) in the particle filter datapath. It replaces hand-addressed block RAM wherever data is consumed in arrival order.

## Interface
- `data_width`, default 16: width of each stored word.
- `addr_width`, default 10: depth is 2**addr_width words. All locations are usable, so the FIFO holds up to 2**addr_width words.
- `af_thresh`, default 1020: `almost_full` asserts when count >= af_thresh.
- `ae_thresh`, default 4: `almost_empty` asserts when count <= ae_thresh.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear, active high.
- `wr_en` input 1: write request.
- `din` input data_width: write data.
- `rd_en` input 1: read request.
- `dout` output data_width: registered read data.
- `dout_valid` output 1: one-cycle pulse, set the cycle after an accepted read.
- `full` output 1: count == 2**addr_width.
- `empty` output 1: count == 0.
- `almost_full` output 1: count >= af_thresh.
- `almost_empty` output 1: count <= ae_thresh.
- `count` output addr_width+1: current occupancy.
- `overflow` output 1: sticky flag, set by a write rejected because the FIFO is full.
- `underflow` output 1: sticky flag, set by a read rejected because the FIFO is empty.

## Operation
- **Pointers:**
  - `wptr` and `rptr` are addr_width+1 bits.
  - The RAM address is the low addr_width bits, so wrap-around is natural modulo 2**addr_width.
  - `count` is held in a register, not derived from the pointers.
- **Write acceptance:** `wr_en && !full`, using the registered `full` at the start of the cycle.
  - Accepted: `din` is stored at `wptr`, and `wptr` increments.
  - Rejected (`wr_en && full`): RAM and pointers are unchanged, and `overflow` is set to 1.
- **Read acceptance:** `rd_en && !empty`, using the registered `empty`.
  - Accepted: RAM[`rptr`] is registered into `dout`, `rptr` increments, and `dout_valid` = 1 next cycle.
  - Rejected (`rd_en && empty`): `dout` holds, `dout_valid` = 0, and `underflow` is set to 1.
- **Simultaneous read and write:** each request is judged independently against the pre-edge flags.
  - Neither full nor empty: both are accepted and `count` is unchanged.
  - When full: the read is accepted and the write is rejected (overflow). `count` ends at 2**addr_width-1.
  - When empty: the write is accepted and the read is rejected (underflow). `count` ends at 1.
- **Flush:**
  - Clears `wptr`, `rptr`, `count`, `dout_valid`, `overflow` and `underflow`.
  - Sets `empty` = 1, `full` = 0, and recomputes the almost flags for count 0.
  - Has priority over `wr_en` and `rd_en` in the same cycle. Both requests are ignored and neither error flag is set.
  - `dout` holds its last value. RAM contents are untouched.
- **Flag updates:** `full`, `empty`, `almost_full` and `almost_empty` are registered and reflect the post-edge `count`.
- **Error flags:** `overflow` and `underflow` clear only on reset or flush.
- **Threshold constraints:** 0 <= ae_thresh < af_thresh <= 2**addr_width. Values outside this range are a configuration error and need no defined behaviour.

## Timing
- **Reset values** (effective immediately on `rst_n` low, independent of `clk`):
  - `dout` = 0, `dout_valid` = 0, `count` = 0, `empty` = 1, `full` = 0.
  - `almost_empty` = 1, `almost_full` = 0, `overflow` = 0, `underflow` = 0.
  - Pointers are 0. RAM contents are not reset.
- **Reset mid-operation:** all in-flight state is discarded. The first edge after `rst_n` rises behaves as a fresh FIFO.
- **Write-to-read latency:** a word written at edge N makes `empty` fall at edge N, so a read may be accepted at edge N+1. Data appears on `dout` after edge N+1.
- **Read latency:** 1 cycle. `dout` and `dout_valid` change on the same edge that accepts the read.
- **Throughput:** one write and one read per cycle sustained, when neither full nor empty.
- **Read-during-write to the same RAM address:** cannot occur. Equal addresses imply the FIFO is empty (read rejected) or full (write rejected).

## Test plan
Bench with `addr_width` = 4 (depth 16), `af_thresh` = 14, `ae_thresh` = 2.
- **Reset:** assert `rst_n` = 0 mid-cycle with random inputs -> all outputs take their reset values before the next edge. `count` = 0, `empty` = 1, `almost_empty` = 1.
- **Fill and drain:**
  - Write 0x0000..0x000F on 16 cycles -> `full` = 1 after the 16th edge, `almost_full` = 1 from `count` = 14.
  - Then read 16 -> `dout` = 0x0000..0x000F in order, `dout_valid` high for 16 cycles, `empty` = 1 at the end, `almost_empty` = 1 from `count` = 2.
- **Overflow and underflow:**
  - Write a 17th word while full -> rejected, `overflow` = 1, `count` = 16, and the stored data is unchanged.
  - Read from empty -> `underflow` = 1, `dout_valid` = 0, `dout` holds.
- **Simultaneous requests:**
  - At full, `wr_en` = `rd_en` = 1 -> `count` = 15, `overflow` = 1.
  - At empty -> `count` = 1, `underflow` = 1.
  - At `count` = 5 -> `count` stays 5, and the data order is preserved.
- **Wrap-around:** stream 40 words with interleaved reads, keeping `count` between 3 and 10 -> all 40 read back in order across pointer wrap, and no error flags are set.
- **Flush:** flush with `count` = 9 and `wr_en` = `rd_en` = 1 -> next cycle `count` = 0, `empty` = 1, `overflow` = `underflow` = 0, `dout` unchanged. A following write/read returns the new word.

Source files
------------

// File: rtl/bram_sync_fifo.sv
// Single-clock FIFO on an inferred block RAM. It keeps a registered occupancy count,
// registered full/empty/almost flags, sticky overflow/underflow flags and a synchronous flush.
module bram_sync_fifo #(
    parameter int data_width = 16,
    parameter int addr_width = 10,
    parameter int af_thresh  = 1020,
    parameter int ae_thresh  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [data_width-1:0] i_din,
    input  logic                  i_rd_en,
    output logic [data_width-1:0] o_dout,
    output logic                  o_dout_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [addr_width:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 2 ** addr_width;
    localparam logic [addr_width:0] C_ONE   = (addr_width + 1)'(1);
    localparam logic [addr_width:0] C_DEPTH = (addr_width + 1)'(DEPTH);
    localparam logic [addr_width:0] C_AF    = (addr_width + 1)'(af_thresh);
    localparam logic [addr_width:0] C_AE    = (addr_width + 1)'(ae_thresh);

    logic [data_width-1:0] r_mem [DEPTH];
    logic [addr_width:0]   r_wptr;
    logic [addr_width:0]   r_rptr;
    logic [addr_width:0]   r_count;
    logic [data_width-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [addr_width:0]   w_count_next;

    // Each request is judged against the registered flags, and flush overrides both.
    assign w_wr_acc = i_wr_en && !r_full  && !i_flush;
    assign w_rd_acc = i_rd_en && !r_empty && !i_flush;

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + C_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_next = r_count - C_ONE;
        end
    end

    // The storage array has no reset, so synthesis can map it onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[addr_width-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_dout         <= '0;
            r_dout_valid   <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wptr       <= '0;
                r_rptr       <= '0;
                r_dout_valid <= 1'b0;
                r_overflow   <= 1'b0;
                r_underflow  <= 1'b0;
            end else begin
                if (w_wr_acc) begin
                    r_wptr <= r_wptr + C_ONE;
                end
                if (w_rd_acc) begin
                    r_rptr <= r_rptr + C_ONE;
                    r_dout <= r_mem[r_rptr[addr_width-1:0]];
                end
                r_dout_valid <= w_rd_acc;
                if (i_wr_en && r_full) begin
                    r_overflow <= 1'b1;
                end
                if (i_rd_en && r_empty) begin
                    r_underflow <= 1'b1;
                end
            end
            // Status flags track the post-edge occupancy.
            r_count        <= w_count_next;
            r_full         <= (w_count_next == C_DEPTH);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= C_AF);
            r_almost_empty <= (w_count_next <= C_AE);
        end
    end

    assign o_dout         = r_dout;
    assign o_dout_valid   = r_dout_valid;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
